fare_coin_collector: RTL and testbench
======================================

Name: fare_coin_collector

Overview:
- Upstream stage of the change-processing block.
- Latches a passenger's destination and quantity selection, looks up the fare, and accumulates inserted coins.
- Presents DESTINATION_OUT, QUA_OUT, COST_OUT, COIN_OUT and a FINISH pulse, which the change stage consumes on its DESTINATION_IN, QUA_IN, COST_IN, COIN_IN and FINISH inputs.
- Cancel and inactivity timeout also end a transaction with FINISH, with COIN_OUT below COST_OUT, so the change stage refunds the coins.

Parameters:
- PRICE_D1, 3, unit fare for destination code 01 (4-bit)
- PRICE_D2, 5, unit fare for destination code 10 (4-bit)
- TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before automatic abort
- TO_W, 10, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- RD_N  in  1  reset; asynchronous assert, active-low
- SEL_VALID  in  1  one-cycle strobe; DEST and QUA are valid
- DEST  in  2  destination code: 01 or 10 valid; 00 and 11 invalid
- QUA  in  2  quantity code: 00 = 1 ticket, 01 = 2 tickets; 1x invalid
- COIN_VALID  in  1  one-cycle strobe; a coin is present
- COIN_CODE  in  2  coin value: 00 = 1, 01 = 2, 10 = 5, 11 = counterfeit
- CANCEL  in  1  passenger abort request (level sampled each cycle)
- DESTINATION_OUT  out  2  latched destination
- QUA_OUT  out  2  latched quantity
- COST_OUT  out  4  fare = unit price * (QUA+1)
- COIN_OUT  out  4  accumulated coin total
- FINISH  out  1  one-cycle transaction-complete pulse
- BUSY  out  1  high in any state other than IDLE
- SEL_ERR  out  1  one-cycle pulse: selection rejected
- COIN_REJ  out  1  one-cycle pulse: coin rejected, physically returned
- ABORTED  out  1  high together with FINISH when the end was caused by cancel or timeout

Behaviour:
- Reset (RD_N = 0, async): state IDLE; every output and internal register is 0.
- States: IDLE, COLLECT, FIN, HOLD. All outputs are registered.
- IDLE:
  - SEL_VALID with a valid DEST/QUA: latch DESTINATION_OUT, QUA_OUT and COST_OUT; clear COIN_OUT and the timeout counter; go to COLLECT next cycle.
  - SEL_VALID with an invalid DEST/QUA: pulse SEL_ERR; stay in IDLE.
  - COIN_VALID in IDLE: pulse COIN_REJ; COIN_OUT is not changed.
  - CANCEL in IDLE has no effect.
- COLLECT:
  - COIN_VALID, code not 11, and COIN_OUT + value <= 15: COIN_OUT += value (5-bit internal sum; no wrap); timeout counter cleared.
  - COIN_VALID, code 11 or sum > 15: pulse COIN_REJ; COIN_OUT unchanged; timeout counter still cleared.
  - Fare met (registered COIN_OUT >= COST_OUT, checked after the update): go to FIN next cycle, ABORTED = 0.
  - CANCEL = 1, or timeout counter reaches TIMEOUT_CYCLES-1 with no coin: go to FIN, ABORTED = 1. Abort takes priority over a coin arriving in the same cycle; that coin is rejected with COIN_REJ.
  - SEL_VALID in COLLECT is ignored; no SEL_ERR.
- FIN:
  - FINISH = 1 for exactly one cycle.
  - All data outputs are stable this cycle and the next (HOLD), so a negative-edge consumer samples them cleanly.
  - Coins arriving in FIN or HOLD: COIN_REJ.
- HOLD:
  - FINISH = 0; ABORTED cleared.
  - Next cycle: IDLE, with COIN_OUT, COST_OUT, DESTINATION_OUT and QUA_OUT cleared to 0.
- Latency:
  - Selection strobe to BUSY = 1 takes 1 cycle.
  - The fare-meeting coin strobe is followed by FINISH 2 cycles later: 1 cycle to accumulate, 1 cycle to enter FIN.
- Fare ranges:
  - Maximum fare is 10 (D2 with 2 tickets), so it fits in 4 bits.
  - Parameter values whose product exceeds 15 are illegal; the bench checks the parameters at elaboration.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. No FINISH is produced, and coins already inserted are not reported.

Decomposition:
- Shared package tvm_pkg, holding:
  - state enum (IDLE, COLLECT, FIN, HOLD)
  - destination codes DEST_D1 = 2'b01 and DEST_D2 = 2'b10
  - coin code constants and the coin value function (code to 4-bit value)
  - quantity codes
- One natural sub-module, fare_lookup: combinational DEST/QUA to COST and valid flag. The change stage's destination decode reuses it.

Test Plan:
- Select DEST = 01, QUA = 00 (fare 3); insert coins 2 then 2 -> COIN_OUT = 4, COST_OUT = 3, FINISH one cycle 2 cycles after the second coin, ABORTED = 0, then all outputs 0 after HOLD.
- Select DEST = 10, QUA = 01 (fare 10); insert 5, 5, 5 -> FINISH after the second 5 with COIN_OUT = 10; the third coin lands in FIN or HOLD and gets COIN_REJ, COIN_OUT stays 10.
- Select DEST = 11 -> SEL_ERR pulse, BUSY stays 0. Select DEST = 01, QUA = 10 -> SEL_ERR.
- Fare 10; insert 5, then 2, then counterfeit (11) -> COIN_OUT = 7, COIN_REJ on the third coin; CANCEL asserted together with a coin 2 -> FINISH with ABORTED = 1, COIN_OUT = 7, coin 2 rejected.
- TIMEOUT_CYCLES = 8; select a fare and insert 1 coin, then idle -> FINISH with ABORTED = 1 exactly 8 cycles after the last coin. Separately: accumulate 14, insert 5 -> COIN_REJ, COIN_OUT stays 14.
- Drop RD_N for one cycle while in COLLECT with COIN_OUT = 4 -> all outputs 0 immediately (asynchronous), no FINISH, and the next selection works normally.

Source files
------------

// File: rtl/tvm_pkg.sv
// Shared types and constants for the ticket vending datapath: FSM states,
// selection/coin encodings and the coin value decode.
package tvm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FIN     = 2'd2,
    HOLD    = 2'd3
  } state_e;

  localparam logic [1:0] DEST_D1 = 2'b01;
  localparam logic [1:0] DEST_D2 = 2'b10;

  localparam logic [1:0] QUA_ONE = 2'b00;
  localparam logic [1:0] QUA_TWO = 2'b01;

  localparam logic [1:0] COIN_1   = 2'b00;
  localparam logic [1:0] COIN_2   = 2'b01;
  localparam logic [1:0] COIN_5   = 2'b10;
  localparam logic [1:0] COIN_BAD = 2'b11;

  function automatic logic [3:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_1:  return 4'd1;
      COIN_2:  return 4'd2;
      COIN_5:  return 4'd5;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/fare_lookup.sv
// Combinational fare table: destination/quantity code to total fare plus a
// validity flag. Also used by the change stage's destination decode.
module fare_lookup
  import tvm_pkg::*;
#(
  parameter int PRICE_D1 = 3,
  parameter int PRICE_D2 = 5
) (
  input  logic [1:0] dest,
  input  logic [1:0] qua,
  output logic [3:0] cost,
  output logic       valid
);

  localparam logic [3:0] P1 = 4'(PRICE_D1);
  localparam logic [3:0] P2 = 4'(PRICE_D2);

  logic [3:0] unit;

  // Two tickets double the unit price; legal prices keep the product in 4 bits.
  always_comb begin
    unit  = (dest == DEST_D2) ? P2 : P1;
    cost  = (qua == QUA_TWO) ? {unit[2:0], 1'b0} : unit;
    valid = ((dest == DEST_D1) || (dest == DEST_D2)) &&
            ((qua == QUA_ONE) || (qua == QUA_TWO));
  end

endmodule

// File: rtl/fare_coin_collector.sv
// Upstream stage of the change block: latches a selection, accumulates coins
// and ends each transaction with a one-cycle FINISH (paid, cancelled or timed out).
module fare_coin_collector
  import tvm_pkg::*;
#(
  parameter int PRICE_D1       = 3,
  parameter int PRICE_D2       = 5,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TO_W           = 10
) (
  input  logic       CLK,
  input  logic       RD_N,
  input  logic       SEL_VALID,
  input  logic [1:0] DEST,
  input  logic [1:0] QUA,
  input  logic       COIN_VALID,
  input  logic [1:0] COIN_CODE,
  input  logic       CANCEL,
  output logic [1:0] DESTINATION_OUT,
  output logic [1:0] QUA_OUT,
  output logic [3:0] COST_OUT,
  output logic [3:0] COIN_OUT,
  output logic       FINISH,
  output logic       BUSY,
  output logic       SEL_ERR,
  output logic       COIN_REJ,
  output logic       ABORTED,
  output state_e     STATE_DBG
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // Strobes (SEL_VALID, COIN_VALID) are single-cycle valids with no ready:
  // each one is consumed or rejected in the cycle it is sampled.
  state_e          state;
  logic [TO_W-1:0] to_cnt;
  logic [3:0]      sel_cost;
  logic            sel_ok;
  logic [4:0]      coin_sum;

  fare_lookup #(
    .PRICE_D1 (PRICE_D1),
    .PRICE_D2 (PRICE_D2)
  ) u_fare_lookup (
    .dest  (DEST),
    .qua   (QUA),
    .cost  (sel_cost),
    .valid (sel_ok)
  );

  assign coin_sum  = {1'b0, COIN_OUT} + {1'b0, coin_value(COIN_CODE)};
  assign STATE_DBG = state;

  always_ff @(posedge CLK or negedge RD_N) begin
    if (!RD_N) begin
      state           <= IDLE;
      to_cnt          <= '0;
      DESTINATION_OUT <= '0;
      QUA_OUT         <= '0;
      COST_OUT        <= '0;
      COIN_OUT        <= '0;
      FINISH          <= 1'b0;
      BUSY            <= 1'b0;
      SEL_ERR         <= 1'b0;
      COIN_REJ        <= 1'b0;
      ABORTED         <= 1'b0;
    end else begin
      FINISH   <= 1'b0;
      SEL_ERR  <= 1'b0;
      COIN_REJ <= 1'b0;
      case (state)
        IDLE: begin
          if (COIN_VALID) COIN_REJ <= 1'b1;
          if (SEL_VALID) begin
            if (sel_ok) begin
              DESTINATION_OUT <= DEST;
              QUA_OUT         <= QUA;
              COST_OUT        <= sel_cost;
              COIN_OUT        <= '0;
              to_cnt          <= '0;
              BUSY            <= 1'b1;
              state           <= COLLECT;
            end else begin
              SEL_ERR <= 1'b1;
            end
          end
        end
        COLLECT: begin
          // A completed payment wins over a late cancel; any coin seen while
          // the transaction is closing is handed back.
          if (COIN_OUT >= COST_OUT) begin
            FINISH  <= 1'b1;
            ABORTED <= 1'b0;
            state   <= FIN;
            if (COIN_VALID) COIN_REJ <= 1'b1;
          end else if (CANCEL || (!COIN_VALID && (to_cnt == TO_LAST))) begin
            FINISH  <= 1'b1;
            ABORTED <= 1'b1;
            state   <= FIN;
            if (COIN_VALID) COIN_REJ <= 1'b1;
          end else if (COIN_VALID) begin
            to_cnt <= '0;
            if ((COIN_CODE != COIN_BAD) && (coin_sum <= 5'd15)) begin
              COIN_OUT <= coin_sum[3:0];
            end else begin
              COIN_REJ <= 1'b1;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        FIN: begin
          ABORTED <= 1'b0;
          state   <= HOLD;
          if (COIN_VALID) COIN_REJ <= 1'b1;
        end
        HOLD: begin
          DESTINATION_OUT <= '0;
          QUA_OUT         <= '0;
          COST_OUT        <= '0;
          COIN_OUT        <= '0;
          BUSY            <= 1'b0;
          state           <= IDLE;
          if (COIN_VALID) COIN_REJ <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fare_coin_collector.sv
// Bench for fare_coin_collector: directed scenarios plus randomized
// transactions checked against a transaction-level fare/coin model.
module tb_fare_coin_collector;
  import tvm_pkg::*;

  localparam int P1 = 3;
  localparam int P2 = 5;
  localparam int TO = 8;
  localparam int TW = 4;

  logic       CLK = 1'b0;
  logic       RD_N = 1'b0;
  logic       SEL_VALID = 1'b0;
  logic [1:0] DEST = 2'b00;
  logic [1:0] QUA = 2'b00;
  logic       COIN_VALID = 1'b0;
  logic [1:0] COIN_CODE = 2'b00;
  logic       CANCEL = 1'b0;
  logic [1:0] DESTINATION_OUT;
  logic [1:0] QUA_OUT;
  logic [3:0] COST_OUT;
  logic [3:0] COIN_OUT;
  logic       FINISH;
  logic       BUSY;
  logic       SEL_ERR;
  logic       COIN_REJ;
  logic       ABORTED;
  state_e     STATE_DBG;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of the open transaction.
  int         m_cost = 0;
  int         m_paid = 0;
  logic [1:0] m_dest = 2'b00;
  logic [1:0] m_qua = 2'b00;

  fare_coin_collector #(
    .PRICE_D1       (P1),
    .PRICE_D2       (P2),
    .TIMEOUT_CYCLES (TO),
    .TO_W           (TW)
  ) dut (
    .CLK             (CLK),
    .RD_N            (RD_N),
    .SEL_VALID       (SEL_VALID),
    .DEST            (DEST),
    .QUA             (QUA),
    .COIN_VALID      (COIN_VALID),
    .COIN_CODE       (COIN_CODE),
    .CANCEL          (CANCEL),
    .DESTINATION_OUT (DESTINATION_OUT),
    .QUA_OUT         (QUA_OUT),
    .COST_OUT        (COST_OUT),
    .COIN_OUT        (COIN_OUT),
    .FINISH          (FINISH),
    .BUSY            (BUSY),
    .SEL_ERR         (SEL_ERR),
    .COIN_REJ        (COIN_REJ),
    .ABORTED         (ABORTED),
    .STATE_DBG       (STATE_DBG)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  initial begin
    if ((P1 * 2 > 15) || (P2 * 2 > 15)) $fatal(1, "illegal price parameters");
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n, input bit in_collect);
    for (int i = 0; i < n; i++) begin
      SEL_VALID = in_collect && ($urandom_range(0, 3) == 0);
      DEST = 2'($urandom_range(0, 3));
      QUA  = 2'($urandom_range(0, 3));
      step();
      SEL_VALID = 1'b0;
      chk("idle_finish", FINISH, 0);
      chk("idle_sel_err", SEL_ERR, 0);
      if (in_collect) begin
        chk("idle_busy", BUSY, 1);
        chk("idle_coin", COIN_OUT, m_paid);
        chk("idle_dest", DESTINATION_OUT, m_dest);
        chk("idle_cost", COST_OUT, m_cost);
      end else begin
        chk("idle_busy_low", BUSY, 0);
      end
    end
  endtask

  task automatic select_ok(input logic [1:0] d, input logic [1:0] q);
    SEL_VALID = 1'b1; DEST = d; QUA = q;
    step();
    SEL_VALID = 1'b0;
    m_dest = d;
    m_qua  = q;
    m_cost = ((d == 2'b01) ? P1 : P2) * (int'(q) + 1);
    m_paid = 0;
    chk("sel_busy", BUSY, 1);
    chk("sel_err_low", SEL_ERR, 0);
    chk("sel_dest", DESTINATION_OUT, m_dest);
    chk("sel_qua", QUA_OUT, m_qua);
    chk("sel_cost", COST_OUT, m_cost);
    chk("sel_coin", COIN_OUT, 0);
  endtask

  task automatic select_bad(input logic [1:0] d, input logic [1:0] q);
    SEL_VALID = 1'b1; DEST = d; QUA = q;
    step();
    SEL_VALID = 1'b0;
    chk("bad_sel_err", SEL_ERR, 1);
    chk("bad_busy", BUSY, 0);
    chk("bad_cost", COST_OUT, 0);
    step();
    chk("bad_sel_err_pulse", SEL_ERR, 0);
    chk("bad_busy_after", BUSY, 0);
  endtask

  task automatic idle_coin();
    COIN_VALID = 1'b1; COIN_CODE = 2'($urandom_range(0, 3));
    step();
    COIN_VALID = 1'b0;
    chk("idle_coin_rej", COIN_REJ, 1);
    chk("idle_coin_total", COIN_OUT, 0);
    chk("idle_coin_busy", BUSY, 0);
  endtask

  task automatic insert(input logic [1:0] code);
    int val;
    bit acc;
    val = (code == 2'b00) ? 1 : (code == 2'b01) ? 2 : (code == 2'b10) ? 5 : 0;
    acc = (code != 2'b11) && (m_paid + val <= 15);
    COIN_VALID = 1'b1; COIN_CODE = code;
    step();
    COIN_VALID = 1'b0;
    if (acc) m_paid += val;
    chk("coin_rej", COIN_REJ, !acc);
    chk("coin_total", COIN_OUT, m_paid);
    chk("coin_finish", FINISH, 0);
    chk("coin_busy", BUSY, 1);
  endtask

  // Closing sequence: FINISH cycle, HOLD cycle, back to IDLE.
  task automatic expect_finish(input bit ab, input bit cancel, input bit c0, input bit c1, input bit c2);
    CANCEL = cancel; COIN_VALID = c0; COIN_CODE = 2'($urandom_range(0, 3));
    step();
    CANCEL = 1'b0; COIN_VALID = 1'b0;
    chk("fin_pulse", FINISH, 1);
    chk("fin_aborted", ABORTED, ab);
    chk("fin_coin", COIN_OUT, m_paid);
    chk("fin_cost", COST_OUT, m_cost);
    chk("fin_dest", DESTINATION_OUT, m_dest);
    chk("fin_qua", QUA_OUT, m_qua);
    chk("fin_rej", COIN_REJ, c0);
    chk("fin_busy", BUSY, 1);
    COIN_VALID = c1; COIN_CODE = 2'($urandom_range(0, 3));
    step();
    COIN_VALID = 1'b0;
    chk("hold_finish", FINISH, 0);
    chk("hold_aborted", ABORTED, 0);
    chk("hold_coin", COIN_OUT, m_paid);
    chk("hold_cost", COST_OUT, m_cost);
    chk("hold_rej", COIN_REJ, c1);
    chk("hold_busy", BUSY, 1);
    COIN_VALID = c2; COIN_CODE = 2'($urandom_range(0, 3));
    step();
    COIN_VALID = 1'b0;
    chk("end_busy", BUSY, 0);
    chk("end_coin", COIN_OUT, 0);
    chk("end_cost", COST_OUT, 0);
    chk("end_dest", DESTINATION_OUT, 0);
    chk("end_qua", QUA_OUT, 0);
    chk("end_finish", FINISH, 0);
    chk("end_rej", COIN_REJ, c2);
  endtask

  task automatic random_txn();
    int mode;
    int stop_at;
    int ncoins;
    select_ok(2'($urandom_range(1, 2)), 2'($urandom_range(0, 1)));
    mode    = $urandom_range(0, 3);
    stop_at = $urandom_range(0, 2);
    ncoins  = 0;
    while ((m_paid < m_cost) && !((mode >= 2) && (ncoins == stop_at)) && (ncoins < 40)) begin
      idle($urandom_range(0, 3), 1'b1);
      insert(2'($urandom_range(0, 3)));
      ncoins++;
    end
    if (m_paid >= m_cost) begin
      expect_finish(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end else if (mode == 2) begin
      idle($urandom_range(0, 3), 1'b1);
      expect_finish(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end else begin
      idle(TO - 1, 1'b1);
      expect_finish(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    if ($urandom_range(0, 2) == 0) idle_coin();
    if ($urandom_range(0, 2) == 0) select_bad(2'b11, 2'($urandom_range(0, 3)));
  endtask

  // Main sequence
  initial begin
    RD_N = 1'b0;
    repeat (3) step();
    chk("rst_busy", BUSY, 0);
    chk("rst_coin", COIN_OUT, 0);
    chk("rst_cost", COST_OUT, 0);
    chk("rst_finish", FINISH, 0);
    chk("rst_state", STATE_DBG, IDLE);
    RD_N = 1'b1;
    step();

    // Fare 3, pay 2 + 2
    select_ok(2'b01, 2'b00);
    insert(2'b01);
    insert(2'b01);
    expect_finish(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fare 10, 5 + 5, third coin during FIN
    select_ok(2'b10, 2'b01);
    insert(2'b10);
    idle(1, 1'b1);
    insert(2'b10);
    expect_finish(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Invalid selections and coins while idle
    select_bad(2'b11, 2'b00);
    select_bad(2'b01, 2'b10);
    select_bad(2'b00, 2'b01);
    select_bad(2'b10, 2'b11);
    idle_coin();
    CANCEL = 1'b1;
    idle(2, 1'b0);
    CANCEL = 1'b0;

    // Counterfeit then cancel together with a coin
    select_ok(2'b10, 2'b01);
    insert(2'b10);
    insert(2'b01);
    insert(2'b11);
    expect_finish(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Inactivity timeout after one coin, and right after selection
    select_ok(2'b01, 2'b01);
    insert(2'b00);
    idle(TO - 1, 1'b1);
    expect_finish(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    select_ok(2'b10, 2'b00);
    idle(TO - 1, 1'b1);
    expect_finish(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Accumulate 14 then offer another 5
    select_ok(2'b10, 2'b01);
    insert(2'b10);
    insert(2'b01);
    insert(2'b01);
    insert(2'b10);
    chk("acc14", COIN_OUT, 14);
    expect_finish(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-transaction
    select_ok(2'b10, 2'b01);
    insert(2'b01);
    insert(2'b01);
    #2;
    RD_N = 1'b0;
    #1;
    chk("arst_busy", BUSY, 0);
    chk("arst_coin", COIN_OUT, 0);
    chk("arst_cost", COST_OUT, 0);
    chk("arst_dest", DESTINATION_OUT, 0);
    chk("arst_qua", QUA_OUT, 0);
    chk("arst_finish", FINISH, 0);
    chk("arst_state", STATE_DBG, IDLE);
    step();
    RD_N = 1'b1;
    idle(TO + 2, 1'b0);
    select_ok(2'b01, 2'b01);
    insert(2'b10);
    insert(2'b00);
    expect_finish(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 60; t++) random_txn();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
